// File: rtl/conv_layer_sched_pkg.sv
// Shared types and defaults for the convolution layer sequencer.
// FSM state type, default layer geometry, index width and a counter-width helper.
package conv_layer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_ACC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int DEF_DIM_IMG    = 32;
    localparam int DEF_DIM_OUT    = 32;
    localparam int DEF_DIM_KERNEL = 5;
    localparam int DEF_IN_CH      = 3;
    localparam int DEF_OUT_CH     = 32;
    localparam int DEF_STRIDE     = 1;
    localparam int DEF_PADDING    = 2;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_AW         = 16;

    // Signed width for row/col/linear-address arithmetic; wide enough that padding offsets never wrap.
    localparam int IDX_W = 32;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// Memory-read, MAC-control and writeback signals between the sequencer and the datapath.
// master = sequencer side, slave = SRAM/MAC/writeback side.
interface conv_layer_sched_if
    import conv_layer_sched_pkg::*;
#(
    parameter int AW = DEF_AW
) ();

    logic          img_rd_en;
    logic [AW-1:0] img_rd_addr;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          bias_rd_en;
    logic [AW-1:0] bias_rd_addr;
    logic          acc_ld_bias;
    logic          acc_en;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;

    modport master (
        output img_rd_en, img_rd_addr,
        output w_rd_en, w_rd_addr,
        output bias_rd_en, bias_rd_addr,
        output acc_ld_bias, acc_en,
        output out_valid, out_addr,
        input  out_ready
    );

    modport slave (
        input  img_rd_en, img_rd_addr,
        input  w_rd_en, w_rd_addr,
        input  bias_rd_en, bias_rd_addr,
        input  acc_ld_bias, acc_en,
        input  out_valid, out_addr,
        output out_ready
    );

endinterface

// File: rtl/conv_layer_sched_delay_line.sv
// Resettable DEPTH-stage shift register; aligns read strobes with SRAM read data at the MAC.
module conv_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Stages packed LSB-first: newest sample at the bottom, oldest at the top.
    logic [DEPTH*WIDTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps <= (DEPTH*WIDTH)'({taps, din});
        end
    end

    assign dout = taps[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer sequencer: walks output pixels and kernel taps, issues SRAM reads,
// drives MAC strobes and hands each finished pixel to the writeback port.
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int DIM_IMG    = DEF_DIM_IMG,
    parameter int DIM_OUT    = DEF_DIM_OUT,
    parameter int DIM_KERNEL = DEF_DIM_KERNEL,
    parameter int IN_CH      = DEF_IN_CH,
    parameter int OUT_CH     = DEF_OUT_CH,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int PADDING    = DEF_PADDING,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int AW         = DEF_AW
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    conv_layer_sched_if.master sched
);

    localparam int IW = cnt_w(OUT_CH);
    localparam int JW = cnt_w(DIM_OUT);
    localparam int MW = cnt_w(DIM_KERNEL);
    localparam int LW = cnt_w(IN_CH);
    localparam int DW = cnt_w(RD_LAT);

    state_t state, state_nx;

    logic [IW-1:0] i, i_nx;
    logic [JW-1:0] j, j_nx;
    logic [JW-1:0] k, k_nx;
    logic [MW-1:0] m, m_nx;
    logic [MW-1:0] n, n_nx;
    logic [LW-1:0] l, l_nx;
    logic [DW-1:0] drain_cnt, drain_nx;

    logic img_en;
    logic bias_en;
    logic out_valid;
    logic tap_valid;

    logic signed [IDX_W-1:0] row, col;
    logic signed [IDX_W-1:0] img_lin, w_lin, out_lin;

    logic [1:0] dly_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            m         <= '0;
            n         <= '0;
            l         <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            i         <= i_nx;
            j         <= j_nx;
            k         <= k_nx;
            m         <= m_nx;
            n         <= n_nx;
            l         <= l_nx;
            drain_cnt <= drain_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        i_nx      = i;
        j_nx      = j;
        k_nx      = k;
        m_nx      = m;
        n_nx      = n;
        l_nx      = l;
        drain_nx  = drain_cnt;
        img_en    = 1'b0;
        bias_en   = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);

        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_BIAS;
            end

            ST_BIAS: begin
                bias_en  = 1'b1;
                state_nx = ST_ACC;
            end

            // One tap per cycle; padding taps still take their cycle but issue no read.
            ST_ACC: begin
                img_en = tap_valid;
                if (l == LW'(IN_CH - 1)) begin
                    l_nx = '0;
                    if (n == MW'(DIM_KERNEL - 1)) begin
                        n_nx = '0;
                        if (m == MW'(DIM_KERNEL - 1)) begin
                            m_nx     = '0;
                            drain_nx = '0;
                            state_nx = ST_DRAIN;
                        end else begin
                            m_nx = m + 1'b1;
                        end
                    end else begin
                        n_nx = n + 1'b1;
                    end
                end else begin
                    l_nx = l + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (drain_cnt == DW'(RD_LAT - 1)) begin
                    drain_nx = '0;
                    state_nx = ST_WRITE;
                end else begin
                    drain_nx = drain_cnt + 1'b1;
                end
            end

            ST_WRITE: begin
                out_valid = 1'b1;
                if (sched.out_ready) begin
                    state_nx = ST_BIAS;
                    if (k == JW'(DIM_OUT - 1)) begin
                        k_nx = '0;
                        if (j == JW'(DIM_OUT - 1)) begin
                            j_nx = '0;
                            if (i == IW'(OUT_CH - 1)) begin
                                i_nx     = '0;
                                state_nx = ST_DONE;
                            end else begin
                                i_nx = i + 1'b1;
                            end
                        end else begin
                            j_nx = j + 1'b1;
                        end
                    end else begin
                        k_nx = k + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                i_nx     = '0;
                j_nx     = '0;
                k_nx     = '0;
                m_nx     = '0;
                n_nx     = '0;
                l_nx     = '0;
                drain_nx = '0;
                state_nx = ST_IDLE;
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    // Tap coordinates go negative at the top/left border, so all index math is signed.
    always_comb begin
        row       = IDX_W'(STRIDE * int'(j) + int'(m) - PADDING);
        col       = IDX_W'(STRIDE * int'(k) + int'(n) - PADDING);
        tap_valid = (row >= 0) && (row < DIM_IMG) && (col >= 0) && (col < DIM_IMG);
        img_lin   = (int'(l) * DIM_IMG + row) * DIM_IMG + col;
        w_lin     = IDX_W'(((int'(i) * IN_CH + int'(l)) * DIM_KERNEL + int'(m)) * DIM_KERNEL + int'(n));
        out_lin   = IDX_W'((int'(i) * DIM_OUT + int'(j)) * DIM_OUT + int'(k));
    end

    assign sched.img_rd_en    = img_en;
    assign sched.img_rd_addr  = img_en ? AW'(img_lin) : '0;
    assign sched.w_rd_en      = img_en;
    assign sched.w_rd_addr    = img_en ? AW'(w_lin) : '0;
    assign sched.bias_rd_en   = bias_en;
    assign sched.bias_rd_addr = bias_en ? AW'(i) : '0;
    assign sched.out_valid    = out_valid;
    assign sched.out_addr     = out_valid ? AW'(out_lin) : '0;

    conv_delay_line #(
        .WIDTH(2),
        .DEPTH(RD_LAT)
    ) u_dly (
        .clk  (clk),
        .reset(reset),
        .din  ({img_en, bias_en}),
        .dout (dly_out)
    );

    assign sched.acc_en      = dly_out[1];
    assign sched.acc_ld_bias = dly_out[0];

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: a loop-nest model of the layer walk is checked
// against the DUT outputs on every cycle, plus literal expectations for key points.
module tb_conv_layer_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic out_ready;
    logic busy0, done0, busy1, done1;

    conv_layer_sched_if #(.AW(16)) bus0 ();
    conv_layer_sched_if #(.AW(16)) bus1 ();

    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;

    conv_layer_sched #(
        .DIM_IMG(4), .DIM_OUT(4), .DIM_KERNEL(3), .IN_CH(1), .OUT_CH(2),
        .STRIDE(1), .PADDING(1), .RD_LAT(1), .AW(16)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0), .sched(bus0.master)
    );

    conv_layer_sched #(
        .DIM_IMG(4), .DIM_OUT(4), .DIM_KERNEL(3), .IN_CH(2), .OUT_CH(2),
        .STRIDE(1), .PADDING(1), .RD_LAT(3), .AW(16)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1), .sched(bus1.master)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        img_en;
        logic [15:0] img_addr;
        logic        w_en;
        logic [15:0] w_addr;
        logic        b_en;
        logic [15:0] b_addr;
        logic        ld;
        logic        acc;
        logic        ov;
        logic [15:0] oaddr;
    } obs_t;

    obs_t ob;
    int   sel = 0;

    always_comb begin
        if (sel == 0) begin
            ob = '{busy0, done0, bus0.img_rd_en, bus0.img_rd_addr, bus0.w_rd_en, bus0.w_rd_addr,
                   bus0.bias_rd_en, bus0.bias_rd_addr, bus0.acc_ld_bias, bus0.acc_en,
                   bus0.out_valid, bus0.out_addr};
        end else begin
            ob = '{busy1, done1, bus1.img_rd_en, bus1.img_rd_addr, bus1.w_rd_en, bus1.w_rd_addr,
                   bus1.bias_rd_en, bus1.bias_rd_addr, bus1.acc_ld_bias, bus1.acc_en,
                   bus1.out_valid, bus1.out_addr};
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    int busy_cycles, hs_seen, done_seen;
    int rd_lat_cur;
    bit hist_img[$];
    bit hist_b[$];
    bit capture_pix0 = 1'b0;
    int pix0[$];
    int w27 = -1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Expected outputs for one busy cycle; MAC strobes are the read strobes RD_LAT cycles earlier.
    task automatic expect_cycle(input bit e_done, input bit e_img, input int e_ia, input int e_wa,
                                input bit e_b, input int e_ba, input bit e_ov, input int e_oa);
        int idx;
        bit e_acc, e_ld;
        hist_img.push_back(e_img);
        hist_b.push_back(e_b);
        idx   = hist_img.size() - 1 - rd_lat_cur;
        e_acc = (idx >= 0) ? hist_img[idx] : 1'b0;
        e_ld  = (idx >= 0) ? hist_b[idx] : 1'b0;
        chk("busy", ob.busy, 1);
        chk("done", ob.done, e_done);
        chk("img_rd_en", ob.img_en, e_img);
        chk("w_rd_en", ob.w_en, e_img);
        if (e_img) begin
            chk("img_rd_addr", ob.img_addr, e_ia);
            chk("w_rd_addr", ob.w_addr, e_wa);
        end
        chk("bias_rd_en", ob.b_en, e_b);
        if (e_b) chk("bias_rd_addr", ob.b_addr, e_ba);
        chk("acc_en", ob.acc, e_acc);
        chk("acc_ld_bias", ob.ld, e_ld);
        chk("out_valid", ob.ov, e_ov);
        if (e_ov) chk("out_addr", ob.oaddr, e_oa);
        if (ob.busy === 1'b1) busy_cycles++;
        if (ob.done === 1'b1) done_seen++;
        if (ob.ov === 1'b1 && out_ready) hs_seen++;
    endtask

    task automatic expect_zero(input bit with_addr);
        chk("idle_busy", ob.busy, 0);
        chk("idle_done", ob.done, 0);
        chk("idle_img_rd_en", ob.img_en, 0);
        chk("idle_w_rd_en", ob.w_en, 0);
        chk("idle_bias_rd_en", ob.b_en, 0);
        chk("idle_acc_en", ob.acc, 0);
        chk("idle_acc_ld_bias", ob.ld, 0);
        chk("idle_out_valid", ob.ov, 0);
        if (with_addr) begin
            chk("rst_img_rd_addr", ob.img_addr, 0);
            chk("rst_w_rd_addr", ob.w_addr, 0);
            chk("rst_bias_rd_addr", ob.b_addr, 0);
            chk("rst_out_addr", ob.oaddr, 0);
        end
    endtask

    // Geometry fixed at DIM_IMG=DIM_OUT=4, K=3, OUT_CH=2, PADDING=1, STRIDE=1.
    task automatic run_layer(input int rd_lat, input int in_ch, input int stall_pix,
                             input int stall_len, input int abort_pix, input int extra_start_pix);
        int p, t, row, col, ia, wa;
        bit v, stall;
        hist_img.delete();
        hist_b.delete();
        rd_lat_cur  = rd_lat;
        busy_cycles = 0;
        hs_seen     = 0;
        done_seen   = 0;
        out_ready   = 1'b1;
        expect_zero(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++)
        for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) begin
            p = (i * 4 + j) * 4 + k;
            if (p == extra_start_pix) start = 1'b1;
            expect_cycle(0, 0, 0, 0, 1, i, 0, 0);
            tick();
            start = 1'b0;
            t = 0;
            for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
            for (int l = 0; l < in_ch; l++) begin
                row = j + m - 1;
                col = k + n - 1;
                v   = (row >= 0) && (row < 4) && (col >= 0) && (col < 4);
                ia  = (l * 4 + row) * 4 + col;
                wa  = ((i * in_ch + l) * 3 + m) * 3 + n;
                expect_cycle(0, v, ia, wa, 0, 0, 0, 0);
                if (capture_pix0 && p == 0 && v) pix0.push_back(int'(ob.img_addr));
                if (in_ch == 2 && i == 1 && j == 1 && k == 1 && l == 1 && m == 0 && n == 0)
                    w27 = int'(ob.w_addr);
                if (p == abort_pix && t == 4) begin
                    reset = 1'b1;
                    tick();
                    expect_zero(1);
                    reset = 1'b0;
                    tick();
                    return;
                end
                tick();
                t++;
            end
            for (int d = 0; d < rd_lat; d++) begin
                expect_cycle(0, 0, 0, 0, 0, 0, 0, 0);
                tick();
            end
            for (int st = 0; st <= stall_len; st++) begin
                stall     = (p == stall_pix) && (st < stall_len);
                out_ready = !stall;
                expect_cycle(0, 0, 0, 0, 0, 0, 1, p);
                tick();
                if (!stall) break;
            end
        end
        expect_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_zero(0);
        tick();
    endtask

    initial begin
        int exp_pix0[4];
        exp_pix0 = '{0, 1, 4, 5};
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        sel       = 0;
        repeat (3) tick();
        expect_zero(1);
        reset = 1'b0;
        tick();

        // Plain layer: 32 handshakes, 12 cycles per pixel plus the DONE cycle.
        capture_pix0 = 1'b1;
        run_layer(1, 1, -1, 0, -1, -1);
        capture_pix0 = 1'b0;
        chk("A_busy_cycles", busy_cycles, 385);
        chk("A_handshakes", hs_seen, 32);
        chk("A_done_count", done_seen, 1);
        chk("pix0_valid_taps", pix0.size(), 4);
        for (int q = 0; q < 4 && q < pix0.size(); q++) chk("pix0_img_addr", pix0[q], exp_pix0[q]);

        // Writeback stall on pixel 3 and an ignored start while busy.
        run_layer(1, 1, 3, 5, -1, 5);
        chk("B_busy_cycles", busy_cycles, 390);
        chk("B_handshakes", hs_seen, 32);
        chk("B_done_count", done_seen, 1);

        // Reset during ACC of pixel 10, then a full rerun from out_addr 0.
        run_layer(1, 1, -1, 0, 10, -1);
        chk("C_done_count", done_seen, 0);
        chk("C_handshakes", hs_seen, 10);
        run_layer(1, 1, -1, 0, -1, -1);
        chk("D_busy_cycles", busy_cycles, 385);
        chk("D_handshakes", hs_seen, 32);
        chk("D_done_count", done_seen, 1);

        // RD_LAT=3, IN_CH=2 instance.
        reset = 1'b1;
        sel   = 1;
        tick();
        expect_zero(1);
        reset = 1'b0;
        tick();
        run_layer(3, 2, -1, 0, -1, -1);
        chk("E_busy_cycles", busy_cycles, 737);
        chk("E_handshakes", hs_seen, 32);
        chk("E_done_count", done_seen, 1);
        chk("E_w_addr_i1_l1_m0_n0", w27, 27);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
